// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: accepts one cipher key and streams round keys 0..10
// over a valid/ready handshake, one new round key per accepted beat.
module aes_key_expand (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0][3:0][7:0]  key,
  input  logic                  key_valid,
  output logic                  key_ready,
  output logic [3:0][3:0][7:0]  rk,
  output logic [3:0]            rk_round,
  output logic                  rk_last,
  output logic                  rk_valid,
  input  logic                  rk_ready
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t                state_q, state_d;
  logic [3:0][3:0][7:0]  rk_q, rk_d;
  logic [3:0]            rk_round_q, rk_round_d;
  logic                  rk_last_q, rk_last_d;
  logic                  rk_valid_q, rk_valid_d;

  logic [7:0]            rcon;
  logic [3:0][7:0]       t_word;
  logic [3:0][3:0][7:0]  rk_next;

  // Rcon for the round being produced (current index + 1).
  always_comb begin
    rcon = 8'h00;
    unique case (rk_round_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Byte 0 is the leftmost byte of a word; RotWord pulls byte 1 into position 0.
  assign t_word[0] = SBOX[rk_q[3][1]] ^ rcon;
  assign t_word[1] = SBOX[rk_q[3][2]];
  assign t_word[2] = SBOX[rk_q[3][3]];
  assign t_word[3] = SBOX[rk_q[3][0]];

  assign rk_next[0] = rk_q[0] ^ t_word;
  assign rk_next[1] = rk_q[1] ^ rk_next[0];
  assign rk_next[2] = rk_q[2] ^ rk_next[1];
  assign rk_next[3] = rk_q[3] ^ rk_next[2];

  assign key_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d    = state_q;
    rk_d       = rk_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid && key_ready) begin
          rk_d       = key;
          rk_round_d = 4'd0;
          rk_valid_d = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (rk_valid_q && rk_ready) begin
          if (rk_round_q == 4'd10) begin
            rk_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            rk_d       = rk_next;
            rk_round_d = rk_round_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rk_last_d = (rk_round_d == 4'd10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rk_q       <= '0;
      rk_round_q <= 4'd0;
      rk_last_q  <= 1'b0;
      rk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_q       <= rk_d;
      rk_round_q <= rk_round_d;
      rk_last_q  <= rk_last_d;
      rk_valid_q <= rk_valid_d;
    end
  end

  assign rk       = rk_q;
  assign rk_round = rk_round_q;
  assign rk_last  = rk_last_q;
  assign rk_valid = rk_valid_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 A.1 and all-zero schedules, backpressure,
// key_valid held during RUN, and reset mid-schedule / held reset.
module tb_aes_key_expand;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0][3:0][7:0]  key;
  logic                  key_valid;
  logic                  key_ready;
  logic [3:0][3:0][7:0]  rk;
  logic [3:0]            rk_round;
  logic                  rk_last;
  logic                  rk_valid;
  logic                  rk_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_rk [11];
  bit           exp_chk [11];

  localparam logic [127:0] KEY_A1   = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk        (rk),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIPS byte i (leftmost first) maps to key[i/4][i%4], i.e. the low byte of the packed vector.
  function automatic logic [3:0][3:0][7:0] to_arr(input logic [127:0] h);
    logic [127:0] r;
    r = {<<8{h}};
    return r;
  endfunction

  function automatic logic [127:0] to_hex(input logic [3:0][3:0][7:0] a);
    logic [127:0] r;
    r = {<<8{a}};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a1();
    exp_rk[0]  = KEY_A1;
    exp_rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    exp_rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    exp_rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    exp_rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    exp_rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    exp_rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    exp_rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    exp_rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    exp_rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    exp_rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    for (int i = 0; i < 11; i++) exp_chk[i] = 1'b1;
  endtask

  task automatic load_zero();
    for (int i = 0; i < 11; i++) begin
      exp_chk[i] = 1'b0;
      exp_rk[i]  = '0;
    end
    exp_chk[0]  = 1'b1;
    exp_chk[1]  = 1'b1;
    exp_chk[2]  = 1'b1;
    exp_chk[10] = 1'b1;
    exp_rk[1]  = 128'h62636363_62636363_62636363_62636363;
    exp_rk[2]  = 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa;
    exp_rk[10] = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;
  endtask

  // Present a key; it is accepted at the next edge where key_ready is high.
  task automatic send_key(input logic [127:0] k, input bit hold);
    int cyc = 0;
    key       = to_arr(k);
    key_valid = 1'b1;
    while (!key_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check("key_ready_timeout", key_ready, 1'b1);
    tick();
    if (!hold) key_valid = 1'b0;
  endtask

  // Consume up to n_beats round keys, checking index, last flag, value and stall stability.
  task automatic collect(input bit bp, input int n_beats, input string tag);
    int beats = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [127:0] prev_rk = '0;
    logic [3:0] prev_round = '0;
    logic prev_last = 1'b0;
    while (beats < n_beats && cyc < 400) begin
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!bp) check({tag, "_no_bubble"}, rk_valid, 1'b1);
      if (stalled) begin
        check({tag, "_stall_valid"}, rk_valid, 1'b1);
        check({tag, "_stall_rk"}, to_hex(rk), prev_rk);
        check({tag, "_stall_round"}, rk_round, prev_round);
        check({tag, "_stall_last"}, rk_last, prev_last);
      end
      stalled = 1'b0;
      if (rk_valid) begin
        if (rk_ready) begin
          check({tag, "_round"}, rk_round, beats[3:0]);
          check({tag, "_last"}, rk_last, (beats == 10));
          if (exp_chk[beats]) check({tag, "_rk"}, to_hex(rk), exp_rk[beats]);
          beats++;
        end else begin
          stalled    = 1'b1;
          prev_rk    = to_hex(rk);
          prev_round = rk_round;
          prev_last  = rk_last;
        end
      end
      tick();
      cyc++;
    end
    check({tag, "_beats"}, beats, n_beats);
    if (n_beats == 11) begin
      check({tag, "_done_valid"}, rk_valid, 1'b0);
      check({tag, "_done_key_ready"}, key_ready, 1'b1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    key       = '0;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    repeat (3) tick();
    check("rst_valid", rk_valid, 1'b0);
    check("rst_rk", to_hex(rk), '0);
    check("rst_round", rk_round, 4'd0);
    check("rst_last", rk_last, 1'b0);
    check("rst_key_ready", key_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("idle_key_ready", key_ready, 1'b1);
    tick();

    // FIPS-197 A.1, no backpressure
    load_a1();
    send_key(KEY_A1, 1'b0);
    collect(1'b0, 11, "a1");
    tick();

    // All-zero key
    load_zero();
    send_key(KEY_ZERO, 1'b0);
    collect(1'b0, 11, "zero");
    tick();

    // A.1 with random backpressure
    load_a1();
    send_key(KEY_A1, 1'b0);
    collect(1'b1, 11, "bp");
    rk_ready = 1'b0;
    tick();

    // key_valid held through RUN with a second (zero) key waiting
    load_a1();
    send_key(KEY_A1, 1'b0);
    key       = to_arr(KEY_ZERO);
    key_valid = 1'b1;
    collect(1'b0, 11, "hold1");
    tick();
    check("hold_second_accept", rk_valid, 1'b1);
    check("hold_second_round0", to_hex(rk), KEY_ZERO);
    key_valid = 1'b0;
    load_zero();
    collect(1'b0, 11, "hold2");
    tick();

    // Reset after round 4 is accepted
    load_a1();
    send_key(KEY_A1, 1'b0);
    collect(1'b0, 5, "pre_rst");
    rst = 1'b1;
    tick();
    check("mid_rst_valid", rk_valid, 1'b0);
    check("mid_rst_rk", to_hex(rk), '0);
    check("mid_rst_round", rk_round, 4'd0);
    check("mid_rst_last", rk_last, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_key_ready", key_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_beat", rk_valid, 1'b0);
    end
    send_key(KEY_A1, 1'b0);
    collect(1'b0, 11, "restart");

    // Reset held with key_valid high
    rst       = 1'b1;
    key       = to_arr(KEY_A1);
    key_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("held_rst_key_ready", key_ready, 1'b0);
      tick();
      check("held_rst_no_beat", rk_valid, 1'b0);
    end
    key_valid = 1'b0;
    rst       = 1'b0;
    repeat (2) tick();
    check("after_rst_no_beat", rk_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
